// File: rtl/popcount_frame_accumulator.sv
// Sums FRAME_LEN 3-bit ones counts into a saturating frame total; result valid 1 cycle after the last accept.
// Backpressure: input is stalled (in_ready=0) while a finished frame waits in HOLD for out_ready.
module popcount_frame_accumulator #(
    parameter int FRAME_LEN = 8,
    parameter int SUM_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [2:0]       out_max,
    output logic             out_overflow
);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [2:0]       max_q, max_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W:0]   sum_ext;

    // One spare bit on top catches the carry that triggers saturation.
    assign sum_ext = {1'b0, acc_q} + {{(SUM_W-2){1'b0}}, in_count};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= '0;
            max_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            max_q   <= max_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        max_d   = max_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            max_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (sum_ext[SUM_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_ext[SUM_W-1:0];
                        end
                        if (in_count > max_q) max_d = in_count;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        cnt_d   = '0;
                        acc_d   = '0;
                        max_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = acc_q;
    assign out_max      = max_q;
    assign out_overflow = ovf_q;
endmodule
